// File: rtl/profile_sampler_if.sv
// profile_sampler_if
//   Custom-instruction (CI) command/response bundle between the sampler and
//   the profiling unit.
//   master : sampler side (drives ciStart/ciN/ciValueA/ciValueB, receives ciDone/ciResult)
//   slave  : profiling-unit side
interface profile_sampler_if;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;

  modport master (output ciStart, ciN, ciValueA, ciValueB, input ciDone, ciResult);
  modport slave  (input ciStart, ciN, ciValueA, ciValueB, output ciDone, ciResult);
endinterface

// File: rtl/profile_sampler.sv
// profile_sampler
//   Configures the four counters of a profiling unit through CI commands and
//   reads back every enabled counter on a manual trigger or a periodic timer.
// Ports
//   clock, nReset          : system clock, asynchronous active-low reset
//   cfgValid/cfgMask/cfgClear/cfgPeriod : one-cycle config request
//   trigger                : one-cycle manual sample request
//   ci (master)            : CI command to / response from the profiling unit
//   sampleValid/sampleIndex/sampleData : one pulse per counter read
//   sampleDone             : one-cycle end-of-sweep pulse
//   busy                   : high whenever not idle
//   overrun, error         : sticky (dropped request / CI response timeout)
module profile_sampler #(
  parameter logic [7:0] customId     = 8'h00,
  parameter int         PERIOD_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    nReset,
  input  logic                    cfgValid,
  input  logic [3:0]              cfgMask,
  input  logic                    cfgClear,
  input  logic [PERIOD_WIDTH-1:0] cfgPeriod,
  input  logic                    trigger,
  profile_sampler_if.master       ci,
  output logic                    sampleValid,
  output logic [1:0]              sampleIndex,
  output logic [31:0]             sampleData,
  output logic                    sampleDone,
  output logic                    busy,
  output logic                    overrun,
  output logic                    error
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CFG_ISSUE = 3'd1;
  localparam logic [2:0] CFG_WAIT  = 3'd2;
  localparam logic [2:0] RD_NEXT   = 3'd3;
  localparam logic [2:0] RD_ISSUE  = 3'd4;
  localparam logic [2:0] RD_WAIT   = 3'd5;
  localparam logic [2:0] FINISH    = 3'd6;

  // Last wait cycle (0-based) in which ciDone is still accepted: 15 cycles.
  localparam logic [3:0] WAIT_LAST = 4'd14;

  logic [2:0]              state_q, state_d;
  logic [3:0]              mask_q, mask_d;
  logic                    clear_q, clear_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic                    pend_q, pend_d;
  logic [2:0]              idx_q, idx_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic                    svld_q, svld_d;
  logic [1:0]              sidx_q, sidx_d;
  logic [31:0]             sdata_q, sdata_d;
  logic                    ovr_q, ovr_d;
  logic                    err_q, err_d;

  logic       tick;
  logic       req_in;
  logic [2:0] nxt;

  // Lowest enabled counter at or above 'from'; 4 when none is left.
  function automatic logic [2:0] next_set(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (3'(i) >= from)) r = 3'(i);
    return r;
  endfunction

  // Timer fires when it would count down to zero, so ticks are exactly
  // period_q cycles apart.
  assign tick   = (period_q != '0) && (timer_q <= PERIOD_WIDTH'(1));
  assign req_in = trigger | tick;
  assign nxt    = next_set(mask_q, idx_q);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    clear_d  = clear_q;
    period_d = period_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    svld_d   = 1'b0;
    sidx_d   = sidx_q;
    sdata_d  = sdata_q;
    ovr_d    = ovr_q;
    err_d    = err_q;

    if (state_q == IDLE && cfgValid) begin
      period_d = cfgPeriod;
      timer_d  = cfgPeriod;
    end else if (tick) begin
      timer_d = period_q;
    end else if (timer_q != '0) begin
      timer_d = timer_q - PERIOD_WIDTH'(1);
    end

    // Requests and configs that find the block busy are dropped, not queued.
    if (state_q != IDLE && (req_in || cfgValid)) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (cfgValid) begin
          mask_d  = cfgMask;
          clear_d = cfgClear;
          pend_d  = pend_q | req_in;
          state_d = CFG_ISSUE;
        end else if (req_in || pend_q) begin
          pend_d  = 1'b0;
          idx_d   = 3'd0;
          state_d = RD_NEXT;
        end
      end
      CFG_ISSUE: begin
        wcnt_d  = 4'd0;
        state_d = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (ci.ciDone) begin
          state_d = IDLE;
        end else if (wcnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      RD_NEXT: begin
        idx_d   = nxt;
        state_d = nxt[2] ? FINISH : RD_ISSUE;
      end
      RD_ISSUE: begin
        wcnt_d  = 4'd0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (ci.ciDone) begin
          svld_d  = 1'b1;
          sidx_d  = idx_q[1:0];
          sdata_d = ci.ciResult;
          idx_d   = idx_q + 3'd1;
          state_d = RD_NEXT;
        end else if (wcnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      clear_q  <= 1'b0;
      period_q <= '0;
      timer_q  <= '0;
      pend_q   <= 1'b0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      svld_q   <= 1'b0;
      sidx_q   <= '0;
      sdata_q  <= '0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      clear_q  <= clear_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      svld_q   <= svld_d;
      sidx_q   <= sidx_d;
      sdata_q  <= sdata_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
    end
  end

  assign ci.ciN      = customId;
  assign ci.ciStart  = (state_q == CFG_ISSUE) || (state_q == RD_ISSUE);
  assign ci.ciValueA = (state_q == RD_ISSUE) ? {30'b0, idx_q[1:0]} : 32'b0;
  assign ci.ciValueB = (state_q == CFG_ISSUE) ?
                       {20'b0, (clear_q ? mask_q : 4'b0), ~mask_q, mask_q} : 32'b0;

  assign sampleValid = svld_q;
  assign sampleIndex = sidx_q;
  assign sampleData  = sdata_q;
  assign sampleDone  = (state_q == FINISH);
  assign busy        = (state_q != IDLE);
  assign overrun     = ovr_q;
  assign error       = err_q;

endmodule

// File: tb/tb_profile_sampler.sv
module tb_profile_sampler;
  localparam logic [7:0] CID = 8'hA5;
  localparam int PW = 16;
  localparam int OP_GAP = 0, OP_ISS = 1, OP_WAIT = 2, OP_FIN = 3;

  logic clock = 1'b0, nReset = 1'b0;
  logic cfgValid = 1'b0, cfgClear = 1'b0, trigger = 1'b0;
  logic [3:0] cfgMask = 4'b0;
  logic [PW-1:0] cfgPeriod = '0;
  logic sampleValid, sampleDone, busy, overrun, error;
  logic [1:0] sampleIndex;
  logic [31:0] sampleData;

  profile_sampler_if ifc();

  profile_sampler #(.customId(CID), .PERIOD_WIDTH(PW)) dut (
    .clock(clock), .nReset(nReset), .cfgValid(cfgValid), .cfgMask(cfgMask),
    .cfgClear(cfgClear), .cfgPeriod(cfgPeriod), .trigger(trigger), .ci(ifc.master),
    .sampleValid(sampleValid), .sampleIndex(sampleIndex), .sampleData(sampleData),
    .sampleDone(sampleDone), .busy(busy), .overrun(overrun), .error(error));

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- responder (profiling unit) ----------------
  int resp_lat = 3, resp_done_cyc = -1;
  bit resp_rand = 0, resp_never = 0, resp_spur = 0;
  logic [31:0] resp_q[$];

  initial begin
    int cnt, lat;
    bit outst;
    ifc.ciDone = 1'b0; ifc.ciResult = 32'b0; outst = 0; cnt = 0;
    forever begin
      @(posedge clock); #1;
      ifc.ciDone = 1'b0;
      if (ifc.ciStart === 1'b1) begin
        lat = resp_rand ? (($urandom_range(0, 19) == 0) ? 16 : int'($urandom_range(1, 6))) : resp_lat;
        outst = !resp_never; cnt = lat;
      end else if (outst) begin
        cnt--;
        if (cnt == 0) begin
          outst = 0; ifc.ciDone = 1'b1; resp_done_cyc = cyc;
          ifc.ciResult = (resp_q.size() != 0) ? resp_q.pop_front() : $urandom;
        end
      end else if (resp_spur && $urandom_range(0, 19) == 0) begin
        ifc.ciDone = 1'b1; ifc.ciResult = $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  // Busy periods are a script of cycle steps planned when a command starts:
  // config = issue, wait; sweep = gap, {issue i, wait i, gap} per enabled i, finish.
  int sc_op[$], sc_ix[$];
  bit m_pend, m_ovr, m_err, m_sv, m_clear;
  logic [3:0] m_mask;
  int m_period, m_next, m_wcnt, m_sidx;
  logic [31:0] m_sdata;

  task automatic m_reset();
    sc_op.delete(); sc_ix.delete();
    m_pend = 0; m_ovr = 0; m_err = 0; m_sv = 0; m_clear = 0;
    m_mask = 4'b0; m_period = 0; m_next = 0; m_wcnt = 0; m_sidx = 0; m_sdata = 32'b0;
  endtask

  task automatic m_push(input int op, input int ix);
    sc_op.push_back(op); sc_ix.push_back(ix);
  endtask

  task automatic m_pop();
    void'(sc_op.pop_front()); void'(sc_ix.pop_front());
  endtask

  task automatic m_step(input int op, input int ix);
    bit tick, req, nsv;
    tick = (m_period != 0) && (cyc == m_next);
    if (tick) m_next = m_next + m_period;
    req = trigger || tick;
    nsv = 0;
    if (op < 0) begin
      if (cfgValid) begin
        m_mask = cfgMask; m_clear = cfgClear; m_pend = m_pend || req;
        m_period = int'(cfgPeriod); m_next = cyc + m_period;
        m_push(OP_ISS, -1); m_push(OP_WAIT, -1);
      end else if (req || m_pend) begin
        m_pend = 0;
        m_push(OP_GAP, 0);
        for (int i = 0; i < 4; i++)
          if (m_mask[i]) begin m_push(OP_ISS, i); m_push(OP_WAIT, i); m_push(OP_GAP, 0); end
        m_push(OP_FIN, 0);
      end
    end else begin
      if (req || cfgValid) m_ovr = 1;
      case (op)
        OP_ISS: begin m_pop(); m_wcnt = 0; end
        OP_WAIT: begin
          if (ifc.ciDone === 1'b1) begin
            if (ix >= 0) begin nsv = 1; m_sidx = ix; m_sdata = ifc.ciResult; end
            m_pop();
          end else begin
            m_wcnt++;
            if (m_wcnt == 15) begin m_err = 1; sc_op.delete(); sc_ix.delete(); end
          end
        end
        default: m_pop();
      endcase
    end
    m_sv = nsv;
  endtask

  // ---------------- event logs for directed checks ----------------
  int samp_idx[$], done_cyc[$], ev[$];
  logic [31:0] samp_dat[$], start_b[$];
  int start_cnt = 0, last_start_cyc = -1, err_rise_cyc = -1;
  bit err_prev = 0;

  task automatic clr_logs();
    samp_idx.delete(); done_cyc.delete(); ev.delete(); samp_dat.delete(); start_b.delete();
    start_cnt = 0; err_rise_cyc = -1;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    int op, ix;
    logic [31:0] eb;
    if (!nReset) begin
      m_reset();
      err_prev = 0;
    end else begin
      op = (sc_op.size() != 0) ? sc_op[0] : -1;
      ix = (sc_op.size() != 0) ? sc_ix[0] : 0;
      eb = (op == OP_ISS && ix < 0) ? {20'b0, (m_clear ? m_mask : 4'b0), ~m_mask, m_mask} : 32'b0;
      chk("ciN", ifc.ciN, CID);
      chk("ciStart", ifc.ciStart, op == OP_ISS);
      chk("ciValueA", ifc.ciValueA, (op == OP_ISS && ix >= 0) ? ix : 0);
      chk("ciValueB", ifc.ciValueB, eb);
      chk("busy", busy, sc_op.size() != 0);
      chk("sampleDone", sampleDone, op == OP_FIN);
      chk("sampleValid", sampleValid, m_sv);
      if (m_sv) begin
        chk("sampleIndex", sampleIndex, m_sidx);
        chk("sampleData", sampleData, m_sdata);
      end
      chk("overrun", overrun, m_ovr);
      chk("error", error, m_err);
      if (sampleValid) begin samp_idx.push_back(int'(sampleIndex)); samp_dat.push_back(sampleData); ev.push_back(int'(sampleIndex)); end
      if (sampleDone) begin done_cyc.push_back(cyc); ev.push_back(99); end
      if (ifc.ciStart) begin start_cnt++; last_start_cyc = cyc; start_b.push_back(ifc.ciValueB); end
      if (error && !err_prev) err_rise_cyc = cyc;
      err_prev = error;
      m_step(op, ix);
    end
  end

  // ---------------- stimulus ----------------
  int cfg_cyc, trig_cyc, busy_low_cyc;

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_cfg(input logic [3:0] m, input bit c, input int p);
    cfgMask = m; cfgClear = c; cfgPeriod = PW'(p); cfgValid = 1'b1; cfg_cyc = cyc;
    step(1);
    cfgValid = 1'b0;
  endtask

  task automatic pulse_trig();
    trigger = 1'b1; trig_cyc = cyc;
    step(1);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin step(1); n++; end
    busy_low_cyc = cyc;
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    // reset state
    step(3);
    chk("rst_busy", busy, 0); chk("rst_start", ifc.ciStart, 0); chk("rst_ciN", ifc.ciN, CID);
    chk("rst_valB", ifc.ciValueB, 0); chk("rst_sv", sampleValid, 0); chk("rst_sd", sampleDone, 0);
    chk("rst_data", sampleData, 0); chk("rst_ovr", overrun, 0); chk("rst_err", error, 0);
    nReset = 1'b1;
    step(2);

    // config command payload and busy release
    resp_lat = 3; clr_logs();
    do_cfg(4'b0101, 1'b1, 0);
    wait_idle(40, "cfg_idle");
    chk("cfg_starts", start_cnt, 1);
    chk("cfg_valueB", (start_b.size() != 0) ? start_b[0] : 32'hdead, 32'h0000_05A5);
    chk("cfg_busy_drop", busy_low_cyc, resp_done_cyc + 1);

    // sweep over counters 1 and 3
    do_cfg(4'b1010, 1'b0, 0);
    wait_idle(40, "cfg2_idle");
    clr_logs(); resp_q.push_back(32'h1234); resp_q.push_back(32'h5678);
    pulse_trig();
    wait_idle(100, "sw_idle");
    chk("sw_events", ev.size(), 3);
    chk("sw_ev0", (ev.size() > 0) ? ev[0] : -1, 1);
    chk("sw_ev1", (ev.size() > 1) ? ev[1] : -1, 3);
    chk("sw_ev2", (ev.size() > 2) ? ev[2] : -1, 99);
    chk("sw_d0", (samp_dat.size() > 0) ? samp_dat[0] : 32'hdead, 32'h1234);
    chk("sw_d1", (samp_dat.size() > 1) ? samp_dat[1] : 32'hdead, 32'h5678);

    // empty mask: sampleDone only, two cycles after the request
    do_cfg(4'b0000, 1'b0, 0);
    wait_idle(40, "m0_cfg_idle");
    clr_logs();
    pulse_trig();
    step(5);
    chk("m0_done_n", done_cyc.size(), 1);
    chk("m0_done_cyc", (done_cyc.size() != 0) ? done_cyc[0] : -1, trig_cyc + 2);
    chk("m0_samples", samp_idx.size(), 0);

    // config and trigger collide: config first, then exactly one sweep
    clr_logs();
    cfgMask = 4'b0011; cfgClear = 1'b0; cfgPeriod = '0; cfgValid = 1'b1; trigger = 1'b1;
    step(1);
    cfgValid = 1'b0; trigger = 1'b0;
    step(60);
    chk("col_first_cmd", (start_b.size() != 0) ? start_b[0] : 32'hdead, 32'h0000_00C3);
    chk("col_starts", start_cnt, 3);
    chk("col_dones", done_cyc.size(), 1);
    chk("col_samples", samp_idx.size(), 2);

    // periodic sweeps; a trigger inside a sweep is dropped
    clr_logs();
    do_cfg(4'b0001, 1'b0, 100);
    c = cfg_cyc;
    chk("per_ovr_pre", overrun, 0);
    while (cyc < c + 330) begin
      trigger = (cyc == c + 203);
      step(1);
    end
    trigger = 1'b0;
    chk("per_dones", done_cyc.size(), 3);
    chk("per_first", (done_cyc.size() > 0) ? done_cyc[0] : -1, c + 107);
    chk("per_gap1", (done_cyc.size() > 1) ? done_cyc[1] - done_cyc[0] : -1, 100);
    chk("per_gap2", (done_cyc.size() > 2) ? done_cyc[2] - done_cyc[1] : -1, 100);
    chk("per_ovr", overrun, 1);
    wait_idle(40, "per_idle");
    do_cfg(4'b0001, 1'b0, 0);
    wait_idle(40, "per_off_idle");

    // CI response never arrives
    resp_never = 1; clr_logs();
    chk("to_err_pre", error, 0);
    pulse_trig();
    step(25);
    chk("to_err", error, 1);
    chk("to_busy", busy, 0);
    chk("to_done", done_cyc.size(), 0);
    chk("to_cyc", err_rise_cyc, last_start_cyc + 16);
    resp_never = 0;

    // randomized traffic, checked cycle by cycle against the model
    resp_rand = 1; resp_spur = 1;
    for (int k = 0; k < 1500; k++) begin
      trigger   = ($urandom_range(0, 11) == 0);
      cfgValid  = ($urandom_range(0, 29) == 0);
      cfgMask   = 4'($urandom);
      cfgClear  = 1'($urandom);
      cfgPeriod = ($urandom_range(0, 2) == 0) ? '0 : PW'($urandom_range(3, 60));
      step(1);
    end
    trigger = 1'b0; cfgValid = 1'b0; resp_rand = 0; resp_spur = 0; resp_lat = 3;
    wait_idle(100, "rnd_idle");
    do_cfg(4'b0100, 1'b0, 0);
    step(60);
    wait_idle(100, "rnd_off_idle");

    // reset while waiting on a read; the late response must be ignored
    resp_lat = 10; clr_logs();
    pulse_trig();
    for (int n = 0; n < 10 && start_cnt == 0; n++) step(1);
    step(2);
    #1 nReset = 1'b0;
    #1;
    chk("mr_busy", busy, 0); chk("mr_start", ifc.ciStart, 0); chk("mr_valA", ifc.ciValueA, 0);
    chk("mr_sv", sampleValid, 0); chk("mr_sd", sampleDone, 0); chk("mr_data", sampleData, 0);
    chk("mr_idx", sampleIndex, 0); chk("mr_ovr", overrun, 0); chk("mr_err", error, 0);
    chk("mr_ciN", ifc.ciN, CID);
    @(posedge clock); #3;
    nReset = 1'b1;
    clr_logs();
    step(20);
    chk("mr_no_sample", samp_idx.size(), 0);
    chk("mr_no_done", done_cyc.size(), 0);
    chk("mr_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
